// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encoding, execute-stage opcode values and small operand helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } md_state_e;

    // Execute-stage opcode encoding shared with the single-cycle alu.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;
    localparam logic [3:0] ALU_REM  = 4'd12;

    localparam logic [31:0] MD_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    // Magnitude of a two's-complement word; INT_MIN maps to itself, which
    // is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic            q_bit,
    output logic [XLEN:0]   rem_out
);

    logic [XLEN+1:0] trial;

    // Trial subtract; the compare uses the full width so no bit is lost.
    always_comb begin
        trial   = {rem_in, dvd_bit};
        q_bit   = (trial >= {2'b00, divisor});
        rem_out = q_bit ? (trial[XLEN:0] - {1'b0, divisor}) : trial[XLEN:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MUL/DIV/REM unit beside the execute-stage alu.
// One shift-add or restoring-divide iteration per cycle on magnitudes,
// signs applied in FIN. Divide-by-zero and INT_MIN/-1 bypass CALC.
//
// state | meaning
// IDLE  | waiting for start with a MUL/DIV/REM opcode
// CALC  | one iteration per cycle, ITER iterations
// FIN   | apply signs, register result, pulse done
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    // MUL: {product high, multiplier/product low}; DIV/REM: low half is
    // the dividend shifting out and the quotient shifting in.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic              res_neg_q, res_neg_d;
    logic              dvd_neg_q, dvd_neg_d;
    logic              dbz_q, dbz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              div_by_zero_q, div_by_zero_d;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic              step_q_bit;
    logic [XLEN:0]     step_rem;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (rem_q),
        .dvd_bit (acc_q[XLEN-1]),
        .divisor (opb_q),
        .q_bit   (step_q_bit),
        .rem_out (step_rem)
    );

    // Radix-2 shift-add: add multiplicand to the high half when the
    // current multiplier bit is set, then shift the whole accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
    end

    // Next-state and datapath for the whole unit.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        acc_d         = acc_q;
        opb_d         = opb_q;
        rem_d         = rem_q;
        res_neg_d     = res_neg_q;
        dvd_neg_d     = dvd_neg_q;
        dbz_d         = dbz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_d      = result_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE: begin
                if (start && is_muldiv_op(alu_op)) begin
                    op_d      = alu_op;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    dbz_d     = 1'b0;
                    rem_d     = '0;
                    res_neg_d = in1[XLEN-1] ^ in2[XLEN-1];
                    dvd_neg_d = in1[XLEN-1];
                    state_d   = CALC;
                    if (alu_op == ALU_MUL) begin
                        acc_d = {{XLEN{1'b0}}, abs32(in2)};
                        opb_d = abs32(in1);
                    end else begin
                        acc_d = {{XLEN{1'b0}}, abs32(in1)};
                        opb_d = abs32(in2);
                        // Special divides preload final values with the
                        // sign flags cleared so FIN passes them through.
                        if (in2 == '0) begin
                            dbz_d     = 1'b1;
                            res_neg_d = 1'b0;
                            dvd_neg_d = 1'b0;
                            acc_d     = {{XLEN{1'b0}}, MD_ALL_ONES};
                            rem_d     = {1'b0, in1};
                            state_d   = FIN;
                        end else if ((in1 == MD_INT_MIN) && (in2 == MD_ALL_ONES)) begin
                            res_neg_d = 1'b0;
                            dvd_neg_d = 1'b0;
                            acc_d     = {{XLEN{1'b0}}, MD_INT_MIN};
                            rem_d     = '0;
                            state_d   = FIN;
                        end
                    end
                end
            end
            CALC: begin
                if (op_q == ALU_MUL) begin
                    acc_d = mul_next;
                end else begin
                    acc_d = {{XLEN{1'b0}}, acc_q[XLEN-2:0], step_q_bit};
                    rem_d = step_rem;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // Low bits of a negated 64-bit product equal the negated
                // low 32 bits, so MUL and DIV share the same expression.
                if (op_q == ALU_REM) begin
                    result_d = dvd_neg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
                end else begin
                    result_d = res_neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
                end
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                cnt_d         = '0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state registers, synchronously reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            acc_q         <= '0;
            opb_q         <= '0;
            rem_q         <= '0;
            res_neg_q     <= 1'b0;
            dvd_neg_q     <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            acc_q         <= acc_d;
            opb_q         <= opb_d;
            rem_q         <= rem_d;
            res_neg_q     <= res_neg_d;
            dvd_neg_q     <= dvd_neg_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus light random checks of muldiv_unit with a result scoreboard.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] in1, in2;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_op      (alu_op),
        .in1         (in1),
        .in2         (in2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int unsigned lat;
        int unsigned issue;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour of the unit, including the special divides.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic dbz, output int unsigned lat);
        logic signed [63:0] p;
        dbz = 1'b0;
        lat = 33;
        if (op == ALU_MUL) begin
            p   = 64'($signed(a)) * 64'($signed(b));
            res = p[31:0];
        end else if (b == 32'd0) begin
            dbz = 1'b1;
            lat = 1;
            res = (op == ALU_DIV) ? 32'hFFFF_FFFF : a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lat = 1;
            res = (op == ALU_DIV) ? 32'h8000_0000 : 32'h0;
        end else if (op == ALU_DIV) begin
            res = $signed(a) / $signed(b);
        end else begin
            res = $signed(a) % $signed(b);
        end
    endtask

    // Output monitor: pops the scoreboard on every done.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            busy_run = 0;
        end else begin
            if (busy === 1'b1) busy_run++;
            if (done === 1'b1) begin
                check_int("done_back_to_back", int'(prev_done), 0);
                check_int("done_with_op_pending", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check32({"result ", e.tag}, result, e.res);
                    check32({"div_by_zero ", e.tag}, 32'(div_by_zero), 32'(e.dbz));
                    check_int({"latency ", e.tag}, int'(cyc - e.issue), int'(e.lat));
                    check_int({"busy_cycles ", e.tag}, busy_run, int'(e.lat));
                end
                busy_run = 0;
            end
        end
        prev_done = done;
    end

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_dbz, input int unsigned exp_lat);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        in1    = a;
        in2    = b;
        @(posedge clk);
        #1;
        e.res   = exp_res;
        e.dbz   = exp_dbz;
        e.lat   = exp_lat;
        e.issue = cyc;
        e.tag   = tag;
        sb.push_back(e);
        start  = 1'b0;
        in1    = $urandom;
        in2    = $urandom;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        check_int({"timeout ", tag}, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic        z;
        int unsigned l;
        logic [3:0]  op;
        logic [31:0] a, b;

        rst    = 1'b1;
        start  = 1'b0;
        alu_op = ALU_ADD;
        in1    = '0;
        in2    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_busy", 32'(busy), 32'd0);
        check32("reset_done", 32'(done), 32'd0);
        check32("reset_result", result, 32'd0);
        check32("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        issue("mul_7_m3", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
        wait_idle("mul_7_m3");
        issue("mul_m1_m1", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        wait_idle("mul_m1_m1");
        issue("mul_ovf", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 33);
        wait_idle("mul_ovf");

        issue("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        wait_idle("div_m7_2");
        issue("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        wait_idle("rem_m7_2");
        issue("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33);
        wait_idle("div_7_m2");

        issue("div_5_0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        wait_idle("div_5_0");
        repeat (3) @(negedge clk);
        check32("dbz_holds", 32'(div_by_zero), 32'd1);
        check32("result_holds", result, 32'hFFFF_FFFF);
        issue("rem_5_0", ALU_REM, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        wait_idle("rem_5_0");
        issue("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        wait_idle("div_ovf");
        issue("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
        wait_idle("rem_ovf");

        // Re-issued start while busy must be ignored.
        issue("mul_restart", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        alu_op = ALU_DIV;
        in1    = 32'd100;
        in2    = 32'd7;
        @(negedge clk);
        start  = 1'b0;
        wait_idle("mul_restart");

        // Unsupported opcode: no busy, no done.
        @(negedge clk);
        start  = 1'b1;
        alu_op = ALU_ADD;
        in1    = 32'd1;
        in2    = 32'd2;
        @(negedge clk);
        start  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("add_no_busy", 32'(busy), 32'd0);
        end
        check32("add_result_kept", result, 32'hFFFF_FFEB);

        // Reset at iteration 10 of a DIV.
        issue("div_reset", ALU_DIV, 32'd1000, 32'd3, 32'd333, 1'b0, 33);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check32("busy_before_reset", 32'(busy), 32'd1);
        void'(sb.pop_back());
        rst = 1'b1;
        @(posedge clk);
        #1;
        check32("rst_mid_busy", 32'(busy), 32'd0);
        check32("rst_mid_result", result, 32'd0);
        check32("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check32("rst_no_late_busy", 32'(busy), 32'd0);

        issue("div_100_7", ALU_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        wait_idle("div_100_7");

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 2))
                0:       op = ALU_MUL;
                1:       op = ALU_DIV;
                default: op = ALU_REM;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            model(op, a, b, r, z, l);
            issue($sformatf("rand%0d", k), op, a, b, r, z, l);
            wait_idle($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
